// File: rtl/photon_hls_deadlock_reporter.sv
// photon_hls_deadlock_reporter: confirms persistent monitor deadlocks and emits one timestamped report per event
module photon_hls_deadlock_reporter #(
  parameter int INFO_W = 9,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W = 16,
  parameter int TS_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block_in,
  input  logic [INFO_W-1:0] axis_block_info_in,
  input  logic              clear,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [INFO_W-1:0] report_info,
  output logic [TS_W-1:0]   report_timestamp,
  output logic [CNT_W-1:0]  report_count,
  output logic              deadlock_sticky,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {IDLE, CONFIRM, REPORT, HOLD} state_t;
  localparam logic [16:0] CC = 17'(CONFIRM_CYCLES);
  state_t state;
  logic [15:0] cnt;
  logic [TS_W-1:0] ts;
  logic confirm;
  // confirm on the edge whose sample of block_in would bring the run length to CONFIRM_CYCLES
  assign confirm = block_in && ((state == IDLE && CC == 17'd1) ||
                                (state == CONFIRM && {1'b0, cnt} + 17'd1 == CC));
  assign state_dbg = state;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      ts               <= '0;
      report_valid     <= 1'b0;
      report_info      <= '0;
      report_timestamp <= '0;
      report_count     <= '0;
      deadlock_sticky  <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (clear) begin
        state           <= IDLE;
        cnt             <= '0;
        report_valid    <= 1'b0;
        report_count    <= '0;
        deadlock_sticky <= 1'b0;
      end else if (confirm) begin
        state            <= REPORT;
        cnt              <= '0;
        report_valid     <= 1'b1;
        report_info      <= axis_block_info_in;
        report_timestamp <= ts;
        report_count     <= report_count + CNT_W'(report_count != '1);
        deadlock_sticky  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (block_in) begin
            state <= CONFIRM;
            cnt   <= 16'd1;
          end
          CONFIRM: begin
            state <= block_in ? CONFIRM : IDLE;
            cnt   <= block_in ? cnt + 16'd1 : 16'd0;
          end
          REPORT: if (report_ready) begin
            state        <= HOLD;
            report_valid <= 1'b0;
          end
          HOLD: state <= block_in ? HOLD : IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_photon_hls_deadlock_reporter.sv
// tb_photon_hls_deadlock_reporter: directed plan plus random traffic against an event-level model
module tb_photon_hls_deadlock_reporter;
  localparam int C = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic block_in = 1'b0;
  logic [8:0] axis_block_info_in = '0;
  logic clear = 1'b0;
  logic report_ready = 1'b0;
  logic report_valid;
  logic [8:0] report_info;
  logic [31:0] report_timestamp;
  logic [15:0] report_count;
  logic deadlock_sticky;
  logic [1:0] state_dbg;

  photon_hls_deadlock_reporter #(.INFO_W(9), .CONFIRM_CYCLES(C), .CNT_W(16), .TS_W(32)) dut (
    .clock(clock), .reset(reset), .block_in(block_in), .axis_block_info_in(axis_block_info_in),
    .clear(clear), .report_valid(report_valid), .report_ready(report_ready), .report_info(report_info),
    .report_timestamp(report_timestamp), .report_count(report_count),
    .deadlock_sticky(deadlock_sticky), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endfunction

  // event-level model: run length of high samples while armed, one pending report, re-arm on a low sample
  logic [31:0] m_ts = '0;
  int m_run = 0;
  bit m_armed = 1'b1;
  bit m_pend = 1'b0;
  logic [8:0] m_info = '0;
  logic [31:0] m_rts = '0;
  int m_count = 0;
  bit m_sticky = 1'b0;

  function automatic logic [1:0] m_state();
    return m_pend ? 2'd2 : !m_armed ? 2'd3 : (m_run > 0) ? 2'd1 : 2'd0;
  endfunction

  always @(posedge reset) begin
    m_ts = '0; m_run = 0; m_armed = 1'b1; m_pend = 1'b0;
    m_info = '0; m_rts = '0; m_count = 0; m_sticky = 1'b0;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (clear) begin
        m_pend = 1'b0; m_count = 0; m_sticky = 1'b0; m_run = 0; m_armed = 1'b1;
      end else if (m_pend) begin
        if (report_ready) begin
          m_pend = 1'b0;
          m_armed = 1'b0;
        end
      end else if (!m_armed) begin
        if (!block_in) m_armed = 1'b1;
      end else if (block_in) begin
        m_run++;
        if (m_run == C) begin
          m_pend = 1'b1; m_info = axis_block_info_in; m_rts = m_ts;
          m_count = (m_count < 65535) ? m_count + 1 : 65535;
          m_sticky = 1'b1; m_run = 0; m_armed = 1'b0;
        end
      end else m_run = 0;
      m_ts = m_ts + 32'd1;
    end
    #1;
    chk("valid", 64'(report_valid), 64'(m_pend));
    chk("info", 64'(report_info), 64'(m_info));
    chk("timestamp", 64'(report_timestamp), 64'(m_rts));
    chk("count", 64'(report_count), 64'(m_count));
    chk("sticky", 64'(deadlock_sticky), 64'(m_sticky));
    chk("state", 64'(state_dbg), 64'(m_state()));
  end

  task automatic drive(input logic b, input logic [8:0] info, input logic rdy, input logic clr);
    block_in = b; axis_block_info_in = info; report_ready = rdy; clear = clr;
    @(negedge clock);
  endtask

  task automatic zero_check(string n);
    chk({n, "_valid"}, 64'(report_valid), 64'd0);
    chk({n, "_info"}, 64'(report_info), 64'd0);
    chk({n, "_ts"}, 64'(report_timestamp), 64'd0);
    chk({n, "_count"}, 64'(report_count), 64'd0);
    chk({n, "_sticky"}, 64'(deadlock_sticky), 64'd0);
    chk({n, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  logic b;
  initial begin
    @(negedge clock); @(negedge clock);
    zero_check("rst");
    reset = 1'b0;
    @(negedge clock);
    // glitch of 15 cycles
    for (int i = 0; i < 15; i++) drive(1'b1, 9'h0AA, 1'b0, 1'b0);
    drive(1'b0, 9'h0AA, 1'b0, 1'b0);
    chk("glitch_valid", 64'(report_valid), 64'd0);
    chk("glitch_count", 64'(report_count), 64'd0);
    chk("glitch_sticky", 64'(deadlock_sticky), 64'd0);
    chk("glitch_state", 64'(state_dbg), 64'd0);
    // first event, ready already high
    for (int i = 0; i < 16; i++) drive(1'b1, 9'h1FE, 1'b1, 1'b0);
    chk("ev1_valid", 64'(report_valid), 64'd1);
    chk("ev1_info", 64'(report_info), 64'h1FE);
    chk("ev1_count", 64'(report_count), 64'd1);
    chk("ev1_sticky", 64'(deadlock_sticky), 64'd1);
    drive(1'b1, 9'h1FE, 1'b1, 1'b0);
    chk("ev1_drop", 64'(report_valid), 64'd0);
    chk("ev1_hold", 64'(state_dbg), 64'd3);
    // sustained deadlock in HOLD
    for (int i = 0; i < 100; i++) drive(1'b1, 9'h1FD, 1'b0, 1'b0);
    chk("hold_valid", 64'(report_valid), 64'd0);
    chk("hold_count", 64'(report_count), 64'd1);
    drive(1'b0, 9'h1FD, 1'b0, 1'b0);
    chk("rearm_state", 64'(state_dbg), 64'd0);
    for (int i = 0; i < 16; i++) drive(1'b1, 9'h1FE, 1'b0, 1'b0);
    chk("ev2_valid", 64'(report_valid), 64'd1);
    chk("ev2_count", 64'(report_count), 64'd2);
    // backpressure while info changes
    for (int i = 0; i < 10; i++) drive(1'b1, 9'h1FD, 1'b0, 1'b0);
    chk("bp_valid", 64'(report_valid), 64'd1);
    chk("bp_info", 64'(report_info), 64'h1FE);
    drive(1'b1, 9'h1FD, 1'b1, 1'b0);
    chk("bp_accept", 64'(report_valid), 64'd0);
    // clear colliding with the handshake
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, 9'h055, 1'b0, 1'b0);
    chk("ev3_count", 64'(report_count), 64'd3);
    drive(1'b1, 9'h055, 1'b1, 1'b1);
    chk("clr_valid", 64'(report_valid), 64'd0);
    chk("clr_count", 64'(report_count), 64'd0);
    chk("clr_sticky", 64'(deadlock_sticky), 64'd0);
    chk("clr_state", 64'(state_dbg), 64'd0);
    chk("clr_info", 64'(report_info), 64'h055);
    drive(1'b1, 9'h055, 1'b0, 1'b0);
    chk("clr_refire", 64'(state_dbg), 64'd1);
    // asynchronous reset mid-confirm
    for (int i = 0; i < 5; i++) drive(1'b1, 9'h033, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 zero_check("arst");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) drive(1'b1, 9'h033, 1'b0, 1'b0);
    chk("arst_early", 64'(report_valid), 64'd0);
    drive(1'b1, 9'h033, 1'b0, 1'b0);
    chk("arst_full", 64'(report_valid), 64'd1);
    chk("arst_count", 64'(report_count), 64'd1);
    // random traffic with long block runs
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) b = ~b;
      drive(b, 9'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
